// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit between execute and data-cache port; define LSU_RMW_EN to enable SB/SH read-modify-write
module load_store_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [4:0]  REQ_RD,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic [4:0]  RSP_RD,
    output logic        RSP_ERR,
    output logic [31:0] RDADDR,
    output logic        RDEN,
    output logic [31:0] WRADDR,
    output logic        WREN,
    output logic [31:0] WRDATA,
    input  logic [31:0] ORDADDR,
    input  logic [31:0] RDOUT,
    input  logic        RDVALID,
    input  logic        LOADING,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_WAIT = 3'd1,
`ifdef LSU_RMW_EN
        S_RMW_RD  = 3'd2,
        S_RMW_WR  = 3'd3,
`endif
        S_ST_WR   = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q, rsp_data_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        err_q, rd_done;
    logic        accept, req_err, rd_state, wr_state, rd_match;
    logic [31:0] word_addr, shifted, load_ext;

    assign accept    = REQ_VALID && REQ_READY;
    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        if (REQ_WE) begin
            case (REQ_FUNCT3)
`ifdef LSU_RMW_EN
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = REQ_ADDR[0];
`endif
                3'b010:  req_err = |REQ_ADDR[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (REQ_FUNCT3)
                3'b000, 3'b100: req_err = 1'b0;
                3'b001, 3'b101: req_err = REQ_ADDR[0];
                3'b010:         req_err = |REQ_ADDR[1:0];
                default:        req_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_state = (state == S_LD_WAIT);
        wr_state = (state == S_ST_WR);
`ifdef LSU_RMW_EN
        rd_state = rd_state || (state == S_RMW_RD);
        wr_state = wr_state || (state == S_RMW_WR);
`endif
    end

    // A return only counts once our own read has been accepted by the cache.
    assign rd_match = rd_state && rd_done && RDVALID && (ORDADDR == word_addr);

    assign shifted = RDOUT >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef LSU_RMW_EN
    logic [31:0] merged;

    always_comb begin
        merged = RDOUT;
        for (int i = 0; i < 4; i++) begin
            if (funct3_q[0]) begin
                if (i[1] == addr_q[1])
                    merged[8*i +: 8] = i[0] ? wdata_q[15:8] : wdata_q[7:0];
            end else if (i[1:0] == addr_q[1:0]) begin
                merged[8*i +: 8] = wdata_q[7:0];
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = S_RESP;
                    else if (!REQ_WE)
                        state_next = S_LD_WAIT;
`ifdef LSU_RMW_EN
                    else if (!REQ_FUNCT3[1])
                        state_next = S_RMW_RD;
`endif
                    else
                        state_next = S_ST_WR;
                end
            end
            S_LD_WAIT: if (rd_match) state_next = S_RESP;
`ifdef LSU_RMW_EN
            S_RMW_RD:  if (rd_match) state_next = S_RMW_WR;
            S_RMW_WR:  if (!LOADING) state_next = S_RESP;
`endif
            S_ST_WR:   if (!LOADING) state_next = S_RESP;
            S_RESP:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = RST && (state == S_IDLE) && !LOADING;
        BUSY      = (state != S_IDLE);
        RDEN      = rd_state && !rd_done;
        RDADDR    = RDEN ? word_addr : 32'd0;
        WREN      = wr_state;
        WRADDR    = wr_state ? word_addr : 32'd0;
        WRDATA    = wr_state ? wdata_q : 32'd0;
        RSP_VALID = (state == S_RESP);
        RSP_DATA  = RSP_VALID ? rsp_data_q : 32'd0;
        RSP_RD    = RSP_VALID ? rd_q : 5'd0;
        RSP_ERR   = RSP_VALID && err_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rsp_data_q <= 32'd0;
            funct3_q   <= 3'd0;
            rd_q       <= 5'd0;
            err_q      <= 1'b0;
            rd_done    <= 1'b0;
        end else if (accept) begin
            addr_q     <= REQ_ADDR;
            wdata_q    <= REQ_WDATA;
            rsp_data_q <= 32'd0;
            funct3_q   <= REQ_FUNCT3;
            rd_q       <= REQ_RD;
            err_q      <= req_err;
            rd_done    <= 1'b0;
        end else begin
            if (RDEN && !LOADING)
                rd_done <= 1'b1;
            if (rd_match && state == S_LD_WAIT)
                rsp_data_q <= load_ext;
`ifdef LSU_RMW_EN
            if (rd_match && state == S_RMW_RD)
                wdata_q <= merged;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [2:0]  REQ_FUNCT3 = 3'd0;
    logic [31:0] REQ_ADDR = 32'd0;
    logic [31:0] REQ_WDATA = 32'd0;
    logic [4:0]  REQ_RD = 5'd0;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic [4:0]  RSP_RD;
    logic        RSP_ERR;
    logic [31:0] RDADDR;
    logic        RDEN;
    logic [31:0] WRADDR;
    logic        WREN;
    logic [31:0] WRDATA;
    logic [31:0] ORDADDR;
    logic [31:0] RDOUT;
    logic        RDVALID;
    logic        LOADING = 1'b0;
    logic        BUSY;

    load_store_unit dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_RD(REQ_RD),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_RD(RSP_RD), .RSP_ERR(RSP_ERR),
        .RDADDR(RDADDR), .RDEN(RDEN), .WRADDR(WRADDR), .WREN(WREN), .WRDATA(WRDATA),
        .ORDADDR(ORDADDR), .RDOUT(RDOUT), .RDVALID(RDVALID), .LOADING(LOADING), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h8899AABB : 32'h01234567;
    endfunction

    // Cache model: return one cycle after an accepted read, optionally inject a stray return.
    logic        stray = 1'b0;
    logic        rd_fire;
    logic [31:0] rd_addr_s;

    initial begin
        RDVALID = 1'b0;
        ORDADDR = 32'd0;
        RDOUT   = 32'd0;
        forever begin
            @(negedge CLK);
            rd_fire   = RDEN && !LOADING;
            rd_addr_s = RDADDR;
            @(posedge CLK);
            #2;
            if (rd_fire) begin
                RDVALID = 1'b1; ORDADDR = rd_addr_s; RDOUT = mem_word(rd_addr_s);
            end else if (stray) begin
                RDVALID = 1'b1; ORDADDR = 32'h200; RDOUT = 32'hDEADBEEF;
            end else begin
                RDVALID = 1'b0; ORDADDR = 32'd0; RDOUT = 32'd0;
            end
        end
    end

    int          first_rden, last_rden, first_wren, rsp_cyc;
    logic [31:0] rd_addr0, wr_addr, wr_data, r_data;
    logic [4:0]  r_rd;
    logic        r_err, addr_stable, ready_low;
    logic [31:0] ld_mask = 32'd0;
    logic [31:0] stray_mask = 32'd0;

    // Called just after a rising edge; that cycle is cycle 0 (the accept cycle).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        first_rden = -1; last_rden = -1; first_wren = -1; rsp_cyc = -1;
        rd_addr0 = 0; wr_addr = 0; wr_data = 0; r_data = 0; r_rd = 0; r_err = 0;
        addr_stable = 1'b1; ready_low = 1'b1;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr;
        REQ_WDATA = wdata; REQ_RD = rd;
        @(negedge CLK);
        check("req_ready_idle", {31'd0, REQ_READY}, 32'd1);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        for (int k = 1; k <= 20 && rsp_cyc < 0; k++) begin
            LOADING = ld_mask[k];
            stray   = stray_mask[k];
            @(negedge CLK);
            if (REQ_READY) ready_low = 1'b0;
            if (RDEN) begin
                if (first_rden < 0) begin
                    first_rden = k; rd_addr0 = RDADDR;
                end else if (RDADDR !== rd_addr0) begin
                    addr_stable = 1'b0;
                end
                last_rden = k;
            end
            if (WREN && first_wren < 0) begin
                first_wren = k; wr_addr = WRADDR; wr_data = WRDATA;
            end
            if (RSP_VALID) begin
                rsp_cyc = k; r_data = RSP_DATA; r_rd = RSP_RD; r_err = RSP_ERR;
            end
            @(posedge CLK);
            #1;
        end
        LOADING = 1'b0;
        stray   = 1'b0;
        check("ready_low_busy", {31'd0, ready_low}, 32'd1);
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp_data);
        run_req(1'b0, f3, addr, 32'd0, 5'd9);
        check({tag, "_rsp_cyc"}, rsp_cyc, 3);
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_err"}, {31'd0, r_err}, 32'd0);
    endtask

    task automatic check_err(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
        run_req(we, f3, addr, 32'hFFFF_FFFF, 5'd3);
        check({tag, "_rsp_cyc"}, rsp_cyc, 1);
        check({tag, "_err"}, {31'd0, r_err}, 32'd1);
        check({tag, "_data"}, r_data, 32'd0);
        check({tag, "_no_rden"}, first_rden, -1);
        check({tag, "_no_wren"}, first_wren, -1);
    endtask

    logic saw_wren, saw_rsp;

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_ctrl", {26'd0, REQ_READY, RSP_VALID, RSP_ERR, RDEN, WREN, BUSY}, 32'd0);
        check("rst_rsp", {RSP_DATA[26:0], RSP_RD}, 32'd0);
        check("rst_addr", RDADDR | WRADDR | WRDATA, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        run_req(1'b0, 3'b000, 32'h103, 32'd0, 5'd5);
        check("lb_rden_cyc", first_rden, 1);
        check("lb_rdaddr", rd_addr0, 32'h100);
        check("lb_rsp_cyc", rsp_cyc, 3);
        check("lb_data", r_data, 32'hFFFFFF88);
        check("lb_rd", {27'd0, r_rd}, 32'd5);

        check_load("lbu", 3'b100, 32'h103, 32'h00000088);
        check_load("lh",  3'b001, 32'h102, 32'hFFFF8899);
        check_load("lhu", 3'b101, 32'h100, 32'h0000AABB);
        check_load("lw",  3'b010, 32'h100, 32'h8899AABB);

        run_req(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 5'd1);
        check("sw_wren_cyc", first_wren, 1);
        check("sw_wraddr", wr_addr, 32'h104);
        check("sw_wrdata", wr_data, 32'hCAFEF00D);
        check("sw_rsp_cyc", rsp_cyc, 2);
        check("sw_no_rden", first_rden, -1);

`ifdef LSU_RMW_EN
        run_req(1'b1, 3'b000, 32'h101, 32'h00000012, 5'd2);
        check("sb_rden_cyc", first_rden, 1);
        check("sb_wren_cyc", first_wren, 3);
        check("sb_wraddr", wr_addr, 32'h100);
        check("sb_wrdata", wr_data, 32'h889912BB);
        check("sb_rsp_cyc", rsp_cyc, 4);
        check("sb_err", {31'd0, r_err}, 32'd0);

        run_req(1'b1, 3'b001, 32'h102, 32'h00005566, 5'd2);
        check("sh_wrdata", wr_data, 32'h5566AABB);
        check("sh_rsp_cyc", rsp_cyc, 4);
`else
        check_err("sb_norMW", 1'b1, 3'b000, 32'h101);
`endif

        check_err("lw_mis", 1'b0, 3'b010, 32'h102);
        check_err("sh_mis", 1'b1, 3'b001, 32'h101);
        check_err("ld_f011", 1'b0, 3'b011, 32'h100);
        check_err("st_f100", 1'b1, 3'b100, 32'h100);

        ld_mask    = 32'h0000000E;
        stray_mask = 32'h00000008;
        run_req(1'b0, 3'b010, 32'h100, 32'd0, 5'd7);
        ld_mask    = 32'd0;
        stray_mask = 32'd0;
        check("stall_first_rden", first_rden, 1);
        check("stall_last_rden", last_rden, 4);
        check("stall_addr_stable", {31'd0, addr_stable}, 32'd1);
        check("stall_rsp_cyc", rsp_cyc, 6);
        check("stall_data", r_data, 32'h8899AABB);

        // Reset in flight: accept at cycle 0, RST low for cycles 2-3.
        saw_wren = 1'b0;
        saw_rsp  = 1'b0;
        REQ_VALID = 1'b1;
`ifdef LSU_RMW_EN
        REQ_WE = 1'b1; REQ_FUNCT3 = 3'b000; REQ_WDATA = 32'h12;
        REQ_ADDR = 32'h101;
`else
        REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_WDATA = 32'h0;
        REQ_ADDR = 32'h100;
`endif
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) RST = 1'b0;
            if (k == 4) RST = 1'b1;
            @(negedge CLK);
            if (WREN) saw_wren = 1'b1;
            if (RSP_VALID) saw_rsp = 1'b1;
            if (k == 2)
                check("midrst_outs", {26'd0, REQ_READY, RSP_VALID, RSP_ERR, RDEN, WREN, BUSY}, 32'd0);
            if (k == 3)
                check("midrst_addr", RDADDR | WRADDR | WRDATA | RSP_DATA, 32'd0);
            if (k == 4)
                check("postrst_ready", {31'd0, REQ_READY}, 32'd1);
            @(posedge CLK);
            #1;
        end
        check("midrst_no_wren", {31'd0, saw_wren}, 32'd0);
        check("midrst_no_rsp", {31'd0, saw_rsp}, 32'd0);
        check_load("postrst_lw", 3'b010, 32'h100, 32'h8899AABB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
